// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Brief    : Shared encodings for the multicycle MIPS control path.
//  Revision : 1.0
// ============================================================================
package mips_pkg;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b011,
      ALU_CMP = 3'b100,
      ALU_NOR = 3'b101
   } alu_ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_NOR = 6'b100111;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_EXEC_R    = 4'd2,
      S_R_WB      = 4'd3,
      S_MEM_ADDR  = 4'd4,
      S_MEM_READ  = 4'd5,
      S_MEM_WB    = 4'd6,
      S_MEM_WRITE = 4'd7,
      S_BRANCH    = 4'd8,
      S_EXEC_I    = 4'd9,
      S_I_WB      = 4'd10,
      S_JUMP      = 4'd11
   } state_t;

   localparam logic [1:0] SRC_B_REG    = 2'b00;
   localparam logic [1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] SRC_B_IMM    = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_if
//  Brief    : Control-unit to datapath/memory bundle.
//  Revision : 1.0
// ============================================================================
interface multicycle_ctrl_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic [2:0] alu_ctrl;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       illegal_op;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output alu_ctrl, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
             ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
             illegal_op
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  alu_ctrl, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
             ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
             illegal_op
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_alu_ctrl_dec.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_dec
//  Brief    : R-type funct to ALU operation decoder with validity flag.
//  Revision : 1.0
// ============================================================================
module alu_ctrl_dec
   import mips_pkg::*;
(
   input  logic [5:0] funct_i,
   output alu_ctrl_t  alu_ctrl_o,
   output logic       valid_o
);

   always_comb begin
      alu_ctrl_o = ALU_ADD;
      valid_o    = 1'b1;
      case (funct_i)
         FN_ADD:  alu_ctrl_o = ALU_ADD;
         FN_SUB:  alu_ctrl_o = ALU_SUB;
         FN_AND:  alu_ctrl_o = ALU_AND;
         FN_OR:   alu_ctrl_o = ALU_OR;
         FN_NOR:  alu_ctrl_o = ALU_NOR;
         default: valid_o    = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Brief    : Multicycle MIPS control FSM driving ALU, memory and PC strobes.
//  Revision : 1.0
// ============================================================================
module multicycle_ctrl
   import mips_pkg::*;
#(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   multicycle_ctrl_if.master  bus
);

   state_t    state_q, state_d;
   logic      is_store_q, is_store_d;
   logic      w_rdy;
   alu_ctrl_t w_fn_ctrl;
   logic      w_fn_valid;

   alu_ctrl_t  w_alu_ctrl;
   logic       w_src_a;
   logic [1:0] w_src_b;
   logic       w_i_or_d;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_ir_write;
   logic       w_pc_write;
   logic [1:0] w_pc_src;
   logic       w_reg_write;
   logic       w_reg_dst;
   logic       w_mem_to_reg;
   logic       w_illegal;

   assign w_rdy = bus.mem_ready | ~MEM_WAIT_EN;

   alu_ctrl_dec u_alu_ctrl_dec (
      .funct_i    (bus.funct),
      .alu_ctrl_o (w_fn_ctrl),
      .valid_o    (w_fn_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         is_store_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      is_store_d   = is_store_q;
      w_alu_ctrl   = ALU_ADD;
      w_src_a      = 1'b0;
      w_src_b      = SRC_B_REG;
      w_i_or_d     = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_src     = PC_SRC_ALU;
      w_reg_write  = 1'b0;
      w_reg_dst    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_illegal    = 1'b0;

      case (state_q)
         S_FETCH: begin
            w_mem_read = 1'b1;
            w_src_b    = SRC_B_FOUR;
            w_ir_write = w_rdy;
            w_pc_write = w_rdy;
            if (w_rdy) state_d = S_DECODE;
         end
         S_DECODE: begin
            // Precompute the branch target into ALUOut while decoding
            w_src_b    = SRC_B_IMM_SH;
            is_store_d = (bus.opcode == OP_SW);
            case (bus.opcode)
               OP_RTYPE:     state_d = S_EXEC_R;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_EXEC_I;
               OP_J:         state_d = S_JUMP;
               default: begin
                  state_d   = S_FETCH;
                  w_illegal = 1'b1;
               end
            endcase
         end
         S_EXEC_R: begin
            w_src_a    = 1'b1;
            w_alu_ctrl = w_fn_ctrl;
            if (w_fn_valid) begin
               state_d = S_R_WB;
            end else begin
               state_d   = S_FETCH;
               w_illegal = 1'b1;
            end
         end
         S_R_WB: begin
            w_reg_write = 1'b1;
            w_reg_dst   = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEM_ADDR: begin
            w_src_a = 1'b1;
            w_src_b = SRC_B_IMM;
            state_d = is_store_q ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            w_mem_read = 1'b1;
            w_i_or_d   = 1'b1;
            if (w_rdy) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEM_WRITE: begin
            w_mem_write = 1'b1;
            w_i_or_d    = 1'b1;
            if (w_rdy) state_d = S_FETCH;
         end
         S_BRANCH: begin
            w_alu_ctrl = ALU_CMP;
            w_src_a    = 1'b1;
            w_pc_src   = PC_SRC_ALUOUT;
            w_pc_write = bus.zero;
            state_d    = S_FETCH;
         end
         S_EXEC_I: begin
            w_src_a = 1'b1;
            w_src_b = SRC_B_IMM;
            state_d = S_I_WB;
         end
         S_I_WB: begin
            w_reg_write = 1'b1;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            w_pc_write = 1'b1;
            w_pc_src   = PC_SRC_JUMP;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // Reset masks every strobe immediately, aborting any pending access
      if (rst) begin
         state_d      = S_FETCH;
         is_store_d   = 1'b0;
         w_alu_ctrl   = ALU_ADD;
         w_src_a      = 1'b0;
         w_src_b      = SRC_B_REG;
         w_i_or_d     = 1'b0;
         w_mem_read   = 1'b0;
         w_mem_write  = 1'b0;
         w_ir_write   = 1'b0;
         w_pc_write   = 1'b0;
         w_pc_src     = PC_SRC_ALU;
         w_reg_write  = 1'b0;
         w_reg_dst    = 1'b0;
         w_mem_to_reg = 1'b0;
         w_illegal    = 1'b0;
      end
   end

   assign bus.alu_ctrl   = w_alu_ctrl;
   assign bus.alu_src_a  = w_src_a;
   assign bus.alu_src_b  = w_src_b;
   assign bus.i_or_d     = w_i_or_d;
   assign bus.mem_read   = w_mem_read;
   assign bus.mem_write  = w_mem_write;
   assign bus.ir_write   = w_ir_write;
   assign bus.pc_write   = w_pc_write;
   assign bus.pc_src     = w_pc_src;
   assign bus.reg_write  = w_reg_write;
   assign bus.reg_dst    = w_reg_dst;
   assign bus.mem_to_reg = w_mem_to_reg;
   assign bus.illegal_op = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Brief    : Directed self-checking bench for the multicycle control FSM.
//  Revision : 1.0
// ============================================================================
module tb_multicycle_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {alu_ctrl, src_a, src_b, i_or_d, mem_read, mem_write, ir_write,
   //  pc_write, pc_src, reg_write, reg_dst, mem_to_reg, illegal_op}
   logic [16:0] outv;
   assign outv = {bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b, bus.i_or_d,
                  bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
                  bus.pc_src, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                  bus.illegal_op};

   localparam logic [16:0] V_RST      = 17'b010_0_00_0_0_0_0_0_00_0_0_0_0;
   localparam logic [16:0] V_FETCH    = 17'b010_0_01_0_1_0_1_1_00_0_0_0_0;
   localparam logic [16:0] V_FETCH_W  = 17'b010_0_01_0_1_0_0_0_00_0_0_0_0;
   localparam logic [16:0] V_DECODE   = 17'b010_0_11_0_0_0_0_0_00_0_0_0_0;
   localparam logic [16:0] V_DEC_ILL  = 17'b010_0_11_0_0_0_0_0_00_0_0_0_1;
   localparam logic [16:0] V_EXEC_SUB = 17'b011_1_00_0_0_0_0_0_00_0_0_0_0;
   localparam logic [16:0] V_EXEC_OR  = 17'b001_1_00_0_0_0_0_0_00_0_0_0_0;
   localparam logic [16:0] V_R_WB     = 17'b010_0_00_0_0_0_0_0_00_1_1_0_0;
   localparam logic [16:0] V_MEM_ADDR = 17'b010_1_10_0_0_0_0_0_00_0_0_0_0;
   localparam logic [16:0] V_MEM_RD   = 17'b010_0_00_1_1_0_0_0_00_0_0_0_0;
   localparam logic [16:0] V_MEM_WB   = 17'b010_0_00_0_0_0_0_0_00_1_0_1_0;
   localparam logic [16:0] V_MEM_WR   = 17'b010_0_00_1_0_1_0_0_00_0_0_0_0;
   localparam logic [16:0] V_BR_T     = 17'b100_1_00_0_0_0_0_1_01_0_0_0_0;
   localparam logic [16:0] V_BR_N     = 17'b100_1_00_0_0_0_0_0_01_0_0_0_0;
   localparam logic [16:0] V_EXEC_I   = 17'b010_1_10_0_0_0_0_0_00_0_0_0_0;
   localparam logic [16:0] V_I_WB     = 17'b010_0_00_0_0_0_0_0_00_1_0_0_0;
   localparam logic [16:0] V_JUMP     = 17'b010_0_00_0_0_0_0_1_10_0_0_0_0;

   task automatic check(input string tag, input logic [16:0] obs,
                        input logic [16:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", tag, obs, exp);
      end
   endtask

   // Apply inputs, check outputs for this cycle, then advance one clock
   task automatic cyc(input string tag, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input logic rdy,
                      input logic r, input logic [16:0] e);
      bus.opcode    = op;
      bus.funct     = fn;
      bus.zero      = z;
      bus.mem_ready = rdy;
      rst           = r;
      #1;
      check(tag, outv, e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.opcode    = 6'b0;
      bus.funct     = 6'b0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset hold then first fetch
      cyc("rst0",  6'b000000, 6'b0, 1'b0, 1'b1, 1'b1, V_RST);
      cyc("rst1",  6'b000000, 6'b0, 1'b0, 1'b1, 1'b1, V_RST);

      // R-type SUB: 4 cycles
      cyc("r_fetch",  6'b000000, 6'b100010, 1'b0, 1'b1, 1'b0, V_FETCH);
      cyc("r_decode", 6'b000000, 6'b100010, 1'b0, 1'b1, 1'b0, V_DECODE);
      cyc("r_exec",   6'b000000, 6'b100010, 1'b0, 1'b1, 1'b0, V_EXEC_SUB);
      cyc("r_wb",     6'b000000, 6'b100010, 1'b0, 1'b1, 1'b0, V_R_WB);

      // R-type OR, with one fetch wait cycle
      cyc("or_fetchw", 6'b000000, 6'b100101, 1'b0, 1'b0, 1'b0, V_FETCH_W);
      cyc("or_fetch",  6'b000000, 6'b100101, 1'b0, 1'b1, 1'b0, V_FETCH);
      cyc("or_decode", 6'b000000, 6'b100101, 1'b0, 1'b1, 1'b0, V_DECODE);
      cyc("or_exec",   6'b000000, 6'b100101, 1'b0, 1'b1, 1'b0, V_EXEC_OR);
      cyc("or_wb",     6'b000000, 6'b100101, 1'b0, 1'b1, 1'b0, V_R_WB);

      // lw with three wait cycles in MEM_READ: 8 cycles
      cyc("lw_fetch",  6'b100011, 6'b0, 1'b0, 1'b1, 1'b0, V_FETCH);
      cyc("lw_decode", 6'b100011, 6'b0, 1'b0, 1'b1, 1'b0, V_DECODE);
      cyc("lw_addr",   6'b100011, 6'b0, 1'b0, 1'b1, 1'b0, V_MEM_ADDR);
      for (int i = 0; i < 3; i++)
         cyc("lw_wait", 6'b100011, 6'b0, 1'b0, 1'b0, 1'b0, V_MEM_RD);
      cyc("lw_read",   6'b100011, 6'b0, 1'b0, 1'b1, 1'b0, V_MEM_RD);
      cyc("lw_wb",     6'b100011, 6'b0, 1'b0, 1'b1, 1'b0, V_MEM_WB);

      // sw, no wait: 4 cycles
      cyc("sw_fetch",  6'b101011, 6'b0, 1'b0, 1'b1, 1'b0, V_FETCH);
      cyc("sw_decode", 6'b101011, 6'b0, 1'b0, 1'b1, 1'b0, V_DECODE);
      cyc("sw_addr",   6'b101011, 6'b0, 1'b0, 1'b1, 1'b0, V_MEM_ADDR);
      cyc("sw_write",  6'b101011, 6'b0, 1'b0, 1'b1, 1'b0, V_MEM_WR);

      // beq taken then not taken: 3 cycles each
      cyc("beqt_fetch",  6'b000100, 6'b0, 1'b1, 1'b1, 1'b0, V_FETCH);
      cyc("beqt_decode", 6'b000100, 6'b0, 1'b1, 1'b1, 1'b0, V_DECODE);
      cyc("beqt_branch", 6'b000100, 6'b0, 1'b1, 1'b1, 1'b0, V_BR_T);
      cyc("beqn_fetch",  6'b000100, 6'b0, 1'b0, 1'b1, 1'b0, V_FETCH);
      cyc("beqn_decode", 6'b000100, 6'b0, 1'b0, 1'b1, 1'b0, V_DECODE);
      cyc("beqn_branch", 6'b000100, 6'b0, 1'b0, 1'b1, 1'b0, V_BR_N);

      // addi: 4 cycles
      cyc("addi_fetch",  6'b001000, 6'b0, 1'b0, 1'b1, 1'b0, V_FETCH);
      cyc("addi_decode", 6'b001000, 6'b0, 1'b0, 1'b1, 1'b0, V_DECODE);
      cyc("addi_exec",   6'b001000, 6'b0, 1'b0, 1'b1, 1'b0, V_EXEC_I);
      cyc("addi_wb",     6'b001000, 6'b0, 1'b0, 1'b1, 1'b0, V_I_WB);

      // j: 3 cycles
      cyc("j_fetch",  6'b000010, 6'b0, 1'b0, 1'b1, 1'b0, V_FETCH);
      cyc("j_decode", 6'b000010, 6'b0, 1'b0, 1'b1, 1'b0, V_DECODE);
      cyc("j_jump",   6'b000010, 6'b0, 1'b0, 1'b1, 1'b0, V_JUMP);

      // Illegal opcode: pulse in DECODE, straight back to FETCH
      cyc("illop_fetch",  6'b111111, 6'b0, 1'b0, 1'b1, 1'b0, V_FETCH);
      cyc("illop_decode", 6'b111111, 6'b0, 1'b0, 1'b1, 1'b0, V_DEC_ILL);

      // Illegal funct: pulse in EXEC_R, no writeback
      cyc("illfn_fetch",  6'b000000, 6'b000001, 1'b0, 1'b1, 1'b0, V_FETCH);
      cyc("illfn_decode", 6'b000000, 6'b000001, 1'b0, 1'b1, 1'b0, V_DECODE);
      bus.opcode = 6'b000000;
      bus.funct  = 6'b000001;
      #1;
      check("illfn_pulse", {16'b0, bus.illegal_op}, 17'd1);
      check("illfn_noreg", {16'b0, bus.reg_write},  17'd0);
      check("illfn_nomem", {16'b0, bus.mem_write},  17'd0);
      @(posedge clk);
      #1;
      check("illfn_back", outv, V_FETCH);
      check("illfn_once", {16'b0, bus.illegal_op}, 17'd0);

      // Reset during a stalled MEM_WRITE aborts the store
      cyc("abort_fetch",  6'b101011, 6'b0, 1'b0, 1'b1, 1'b0, V_FETCH);
      cyc("abort_decode", 6'b101011, 6'b0, 1'b0, 1'b1, 1'b0, V_DECODE);
      cyc("abort_addr",   6'b101011, 6'b0, 1'b0, 1'b1, 1'b0, V_MEM_ADDR);
      cyc("abort_wait",   6'b101011, 6'b0, 1'b0, 1'b0, 1'b0, V_MEM_WR);
      cyc("abort_rst",    6'b101011, 6'b0, 1'b0, 1'b0, 1'b1, V_RST);
      cyc("abort_fetch2", 6'b000000, 6'b0, 1'b0, 1'b1, 1'b0, V_FETCH);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle MIPS control unit. It is the driving end of the ALU interface: it sequences fetch, decode, execute, memory and writeback, and emits alu_ctrl, operand selects and datapath strobes. It consumes the ALU zero flag for branch resolution and a memory ready handshake. It sits in the core top level beside the ALU, register file, instruction register and memory port.

Parameters:
MEM_WAIT_EN, 1, 1 = memory states hold until mem_ready; 0 = mem_ready is ignored and treated as 1.

Ports:
clk  input  1  core clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
opcode  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
zero  input  1  ALU zero flag, same-cycle
mem_ready  input  1  memory completes the access this cycle
alu_ctrl  output  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 compare (result 0, zero=1 if equal), 101 NOR
alu_src_a  output  1  0 = PC, 1 = reg A
alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  load instruction register
pc_write  output  1  PC load enable, unconditional or branch-taken
pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target
reg_write  output  1  register file write
reg_dst  output  1  0 = rt, 1 = rd
mem_to_reg  output  1  0 = ALUOut, 1 = MDR
illegal_op  output  1  one-cycle pulse on unsupported opcode or funct

Behaviour:
- Reset: synchronous; state goes to FETCH on the next edge. While rst=1 every strobe is 0, alu_ctrl=010, and all selects are 0.
- Outputs are decoded from the state. Exception: pc_write in BRANCH equals zero.
- FETCH: mem_read=1, i_or_d=0, alu_ctrl=ADD, src_a=0, src_b=01, pc_src=00. ir_write and pc_write equal mem_ready. The state stays in FETCH while mem_ready=0, otherwise goes to DECODE.
- DECODE: alu_ctrl=ADD, src_a=0, src_b=11 (branch target to ALUOut). Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 (lw) and 101011 (sw) -> MEM_ADDR
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> EXEC_I
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH with illegal_op=1
- EXEC_R: src_a=1, src_b=00. alu_ctrl from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR. Goes to R_WB. Any other funct -> FETCH with illegal_op=1 and no writeback.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- MEM_ADDR: ADD, src_a=1, src_b=10. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready, then goes to FETCH.
- BRANCH: alu_ctrl=100, src_a=1, src_b=00, pc_src=01, pc_write=zero. Goes to FETCH.
- EXEC_I: ADD, src_a=1, src_b=10. Goes to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- JUMP: pc_write=1, pc_src=10. Goes to FETCH.
- Latency in cycles, with mem_ready=1: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3. Each cycle of mem_ready=0 adds one cycle.
- Strobes mem_read, mem_write, reg_write and pc_write are never asserted in the same cycle with another write-class strobe, except the FETCH pair ir_write+pc_write.
- rst=1 during a wait state aborts the access: strobes drop in the same cycle and the next state is FETCH.
- opcode and funct are sampled only in DECODE and EXEC_R; the instruction register is stable after FETCH.
- Unreachable state encodings recover to FETCH.

Decomposition:
- Shared package mips_pkg holds:
  - alu_ctrl_t enum: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_CMP, ALU_NOR
  - opcode and funct localparams
  - state_t enum
  - src_b and pc_src encodings
- Sub-module alu_ctrl_dec (combinational): funct -> alu_ctrl_t plus a valid flag. It is reusable by a future pipelined core.

Test Plan:
1. rst=1 for 2 cycles with mem_ready=1 -> all strobes 0, alu_ctrl=010. On the first cycle after release: FETCH, with mem_read=1, ir_write=1, pc_write=1, src_b=01.
2. R-type, opcode=0, funct=100010 -> EXEC_R drives alu_ctrl=011, src_a=1, src_b=00. Next cycle reg_write=1, reg_dst=1. Back in FETCH at cycle 5.
3. lw, opcode=100011, mem_ready low for 3 cycles in MEM_READ -> mem_read=1, i_or_d=1 is held 4 cycles. MEM_WB has mem_to_reg=1, reg_write=1. Total 8 cycles.
4. beq, opcode=000100, run twice with zero=1 then zero=0 -> BRANCH alu_ctrl=100, pc_src=01. pc_write is 1 for zero=1 and 0 for zero=0. 3 cycles each.
5. Illegal opcode 111111 and illegal funct 000001 -> each gives a single illegal_op pulse, return to FETCH, no reg_write or mem_write.
6. rst asserted mid-MEM_WRITE with mem_ready=0 -> mem_write drops in the same cycle; FETCH follows release; no write strobe seen.
